// File: rtl/alu_op_decoder.sv
// RV32 ALU-op decoder feeding a 2-entry FIFO of {illegal, use_imm, op}.
// Optional saturating illegal-instruction counter under `ALU_DEC_ERRCNT_EN.
module alu_op_decoder #(
   parameter int ERRCNT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_op,
   output logic        out_use_imm,
   output logic        out_illegal
`ifdef ALU_DEC_ERRCNT_EN
   ,
   output logic [ERRCNT_W-1:0] err_count
`endif
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_bits;

   assign opcode      = in_instr[6:0];
   assign funct3      = in_instr[14:12];
   assign funct7      = in_instr[31:25];
   assign unused_bits = ^{in_instr[24:15], in_instr[11:7]};

   logic [3:0] dec_op;
   logic       dec_imm;
   logic       dec_ill;
   logic [3:0] f3_op;

   always_comb begin
      f3_op = OP_ADD;
      case (funct3)
         3'b000: f3_op = OP_ADD;
         3'b001: f3_op = OP_SLL;
         3'b010: f3_op = OP_SLT;
         3'b011: f3_op = OP_SLTU;
         3'b100: f3_op = OP_XOR;
         3'b101: f3_op = OP_SRL;
         3'b110: f3_op = OP_OR;
         default: f3_op = OP_AND;
      endcase
   end

   always_comb begin
      dec_op  = 4'b0000;
      dec_imm = 1'b0;
      dec_ill = 1'b1;
      if (opcode == 7'b0110011) begin
         if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
            dec_op  = OP_SUB;
            dec_ill = 1'b0;
         end else if (funct7 == 7'b0000000) begin
            dec_op  = f3_op;
            dec_ill = 1'b0;
         end
      end else if (opcode == 7'b0010011) begin
         // Only the shifts encode anything in funct7 for immediates
         if (!((funct3 == 3'b001 || funct3 == 3'b101) && funct7 != 7'b0000000)) begin
            dec_op  = f3_op;
            dec_imm = 1'b1;
            dec_ill = 1'b0;
         end
      end
   end

   logic [5:0] mem [2];
   logic [1:0] count;
   logic       wr_ptr;
   logic       rd_ptr;
   logic       push;
   logic       pop;
   logic [5:0] head;

   assign in_ready  = rst || (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && !rst && (count != 2'd2);
   assign pop       = out_valid && out_ready;
   assign head      = mem[rd_ptr];

   assign out_op      = out_valid ? head[3:0] : 4'b0000;
   assign out_use_imm = out_valid ? head[4]   : 1'b0;
   assign out_illegal = out_valid ? head[5]   : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {dec_ill, dec_imm, dec_op};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         if (push && !pop)
            count <= count + 2'd1;
         else if (pop && !push)
            count <= count - 2'd1;
      end
   end

`ifdef ALU_DEC_ERRCNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         err_count <= '0;
      else if (push && dec_ill && err_count != {ERRCNT_W{1'b1}})
         err_count <= err_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: decode table, FIFO backpressure, reset.
// err_count checks are included when ALU_DEC_ERRCNT_EN is defined.
module tb_alu_op_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op;
   logic        out_use_imm;
   logic        out_illegal;
`ifdef ALU_DEC_ERRCNT_EN
   logic [7:0]  err_count;
`endif

   int errors = 0;
   int checks = 0;

   alu_op_decoder #(.ERRCNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_op      (out_op),
      .out_use_imm (out_use_imm),
      .out_illegal (out_illegal)
`ifdef ALU_DEC_ERRCNT_EN
      ,
      .err_count   (err_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00B50533; out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      step();
      step();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_op, out_use_imm, out_illegal, in_ready} !== 8'b0_0000_0_0_1) begin
         errors++;
         $display("FAIL reset_state got v=%b op=%b imm=%b ill=%b rdy=%b exp v=0 op=0000 imm=0 ill=0 rdy=1",
                  out_valid, out_op, out_use_imm, out_illegal, in_ready);
      end
`ifdef ALU_DEC_ERRCNT_EN
      checks++;
      if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got=%0d exp=0", err_count); end
`endif
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  op;
      logic        imm;
      logic        ill;
   } vec_t;

   task automatic run_vectors(input vec_t v[$], input string tag);
      foreach (v[i]) begin
         in_valid = 1'b1; in_instr = v[i].instr; out_ready = 1'b1;
         step();
         in_valid = 1'b0;
         checks++;
         if ({out_valid, out_op, out_use_imm, out_illegal} !== {1'b1, v[i].op, v[i].imm, v[i].ill}) begin
            errors++;
            $display("FAIL %s[%0d] instr=%h got v=%b op=%b imm=%b ill=%b exp v=1 op=%b imm=%b ill=%b",
                     tag, i, v[i].instr, out_valid, out_op, out_use_imm, out_illegal,
                     v[i].op, v[i].imm, v[i].ill);
         end
         step();
         checks++;
         if ({out_valid, out_op, out_use_imm, out_illegal} !== 7'b0) begin
            errors++;
            $display("FAIL %s_empty[%0d] got v=%b op=%b imm=%b ill=%b exp all 0",
                     tag, i, out_valid, out_op, out_use_imm, out_illegal);
         end
      end
   endtask

   task automatic test_illegal();
      vec_t v[$];
      v.push_back('{32'h40355513, 4'b0000, 1'b0, 1'b1});
      v.push_back('{32'h00000073, 4'b0000, 1'b0, 1'b1});
      run_vectors(v, "illegal");
`ifdef ALU_DEC_ERRCNT_EN
      checks++;
      if (err_count !== 8'd2) begin errors++; $display("FAIL errcnt_two got=%0d exp=2", err_count); end
`endif
   endtask

   task automatic test_decode();
      vec_t v[$];
      v.push_back('{32'h40B50533, 4'b0001, 1'b0, 1'b0});
      v.push_back('{32'h00B50533, 4'b0000, 1'b0, 1'b0});
      v.push_back('{32'h00B53533, 4'b1000, 1'b0, 1'b0});
      v.push_back('{32'h00B51533, 4'b0101, 1'b0, 1'b0});
      v.push_back('{32'h40B54533, 4'b0000, 1'b0, 1'b1});
      v.push_back('{32'h00A50513, 4'b0000, 1'b1, 1'b0});
      v.push_back('{32'h00351513, 4'b0101, 1'b1, 1'b0});
      v.push_back('{32'h00355513, 4'b0110, 1'b1, 1'b0});
      v.push_back('{32'h00352513, 4'b0111, 1'b1, 1'b0});
      v.push_back('{32'h40354513, 4'b0011, 1'b1, 1'b0});
      v.push_back('{32'hFE050513, 4'b0000, 1'b1, 1'b0});
      v.push_back('{32'h40351513, 4'b0000, 1'b0, 1'b1});
      run_vectors(v, "decode");
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00B57533;
      step();
      checks++;
      if ({in_ready, out_valid, out_op} !== 6'b1_1_0010) begin
         errors++; $display("FAIL bp_first got rdy=%b v=%b op=%b exp rdy=1 v=1 op=0010", in_ready, out_valid, out_op);
      end
      in_instr = 32'h00B54533;
      step();
      checks++;
      if ({in_ready, out_op} !== 5'b0_0010) begin
         errors++; $display("FAIL bp_full got rdy=%b op=%b exp rdy=0 op=0010", in_ready, out_op);
      end
      in_instr = 32'h00B56533;
      step();
      checks++;
      if ({in_ready, out_valid, out_op} !== 6'b0_1_0010) begin
         errors++; $display("FAIL bp_hold got rdy=%b v=%b op=%b exp rdy=0 v=1 op=0010", in_ready, out_valid, out_op);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if ({in_ready, out_valid, out_op} !== 6'b1_1_0011) begin
         errors++; $display("FAIL bp_pop1 got rdy=%b v=%b op=%b exp rdy=1 v=1 op=0011", in_ready, out_valid, out_op);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid, out_op} !== 6'b1_1_0100) begin
         errors++; $display("FAIL bp_pop2 got rdy=%b v=%b op=%b exp rdy=1 v=1 op=0100", in_ready, out_valid, out_op);
      end
      step();
      checks++;
      if ({out_valid, out_op} !== 5'b0_0000) begin
         errors++; $display("FAIL bp_drain got v=%b op=%b exp v=0 op=0000", out_valid, out_op);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] instrs [4] = '{32'h00B50533, 32'h40B50533, 32'h00B57533, 32'h00B54533};
      logic [3:0]  ops    [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_instr = instrs[i];
         step();
         checks++;
         if ({in_ready, out_valid, out_op} !== {2'b11, ops[i]}) begin
            errors++;
            $display("FAIL b2b[%0d] got rdy=%b v=%b op=%b exp rdy=1 v=1 op=%b", i, in_ready, out_valid, out_op, ops[i]);
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_full();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00000073;
      step();
      step();
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rstfull_rdy got=%b exp=1", in_ready); end
      step();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, out_illegal} !== 3'b010) begin
         errors++; $display("FAIL rstfull_state got v=%b rdy=%b ill=%b exp v=0 rdy=1 ill=0", out_valid, in_ready, out_illegal);
      end
`ifdef ALU_DEC_ERRCNT_EN
      checks++;
      if (err_count !== 8'd0) begin errors++; $display("FAIL rstfull_errcnt got=%0d exp=0", err_count); end
`endif
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_nostore got v=%b exp=0", out_valid); end
   endtask

`ifdef ALU_DEC_ERRCNT_EN
   task automatic test_saturate();
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 32'h40355513;
      for (int i = 0; i < 300; i++) step();
      in_valid = 1'b0;
      step();
      checks++;
      if (err_count !== 8'd255) begin errors++; $display("FAIL errcnt_sat got=%0d exp=255", err_count); end
   endtask
`endif

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
      test_reset();
      test_illegal();
      test_decode();
      test_backpressure();
      test_back_to_back();
      test_reset_full();
`ifdef ALU_DEC_ERRCNT_EN
      test_saturate();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_op_decoder.md
ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 Parameter: ERRCNT_W, 8, width of the illegal-instruction counter (active only with ALU_DEC_ERRCNT_EN).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream presents an instruction.
REQ-005 in_ready  output  1  decoder can accept; transfer when in_valid && in_ready at a rising edge.
REQ-006 in_instr  input  32  RV32 instruction word; fields are opcode[6:0], funct3[14:12] and funct7[31:25].
REQ-007 out_valid  output  1  decoded entry available.
REQ-008 out_ready  input  1  ALU side consumes; pop when out_valid && out_ready at a rising edge.
REQ-009 out_op  output  4  ALU op code.
REQ-010 out_use_imm  output  1  1 = I-type (operand B is the immediate).
REQ-011 out_illegal  output  1  instruction not decodable to an ALU op.
REQ-012 err_count  output  ERRCNT_W  saturating count of illegal instructions accepted (present only with ALU_DEC_ERRCNT_EN).

Function
REQ-013 Op codes SHALL be: add 0000, sub 0001, and 0010, xor 0011, or 0100, sll 0101, srl 0110, slt 0111, sltu 1000.
REQ-014 The R-type opcode 0110011 SHALL decode by funct3 as follows:
- 000: add if funct7=0000000; sub if funct7=0100000.
- 001: sll; 010: slt; 011: sltu; 100: xor; 101: srl; 110: or; 111: and.
- Every funct3 except 000 requires funct7=0000000.
REQ-015 The I-type opcode 0010011 SHALL decode by funct3 as follows:
- 000: add, with funct7 ignored.
- 001: sll and 101: srl, both requiring funct7=0000000.
- The other funct3 values decode as for R-type, with funct7 ignored.
- out_use_imm=1.
REQ-016 Any other opcode or funct7 combination (including srai/sra, funct7=0100000 with funct3=101) SHALL produce out_illegal=1, out_op=0000 and out_use_imm=0, and SHALL still be queued and delivered.
REQ-017 Decode SHALL be computed combinationally from in_instr and stored into a 2-entry FIFO (storage for op, use_imm and illegal); outputs come from the head entry only.
REQ-018 Latency SHALL be one cycle: an entry accepted at edge N into an empty FIFO gives out_valid=1 after edge N.
REQ-019 in_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries; it is registered-state based and never depends combinationally on out_ready.
REQ-020 When push and pop occur at the same edge, occupancy SHALL be unchanged, and order SHALL be strictly FIFO.
REQ-021 At occupancy 2 the FIFO SHALL ignore in_valid, and no entry SHALL be overwritten or dropped.
REQ-022 While out_valid=1 and out_ready=0, out_op, out_use_imm and out_illegal SHALL hold stable.
REQ-023 FIFO read/write pointers SHALL wrap modulo 2.
REQ-024 When out_valid=0, out_op, out_use_imm and out_illegal SHALL be driven to 0.

Reset
REQ-025 On rst=1 at a rising edge, the block SHALL clear occupancy and both pointers, giving out_valid=0, out_op=0000, out_use_imm=0, out_illegal=0, in_ready=1 and err_count=0.
REQ-026 Reset SHALL take priority over simultaneous push and pop; in-flight entries are discarded.
REQ-027 While rst=1, in_ready SHALL still read 1, and no transfer SHALL be counted or stored.

Configuration
REQ-028 Macro ALU_DEC_ERRCNT_EN:
- When defined, the err_count port and logic SHALL exist. The count increments by 1 on each accepted instruction with out_illegal=1 and saturates at all-ones.
- When undefined, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset then in_instr=0x40B50533 (sub) with out_ready=1 -> next cycle out_valid=1, out_op=0001, out_use_imm=0, out_illegal=0.
REQ-030 Hold out_ready=0 and push 0x00B57533 (and), 0x00B54533 (xor) and 0x00B56533 (or) -> in_ready=0 after the second push; outputs hold at 0010; then pop yields 0010, 0011 in order, and the third instruction is accepted only once in_ready=1.
REQ-031 I-type instructions 0x00A50513 (addi) and 0x00351513 (slli) -> out_op=0000 then 0101, with out_use_imm=1 for both.
REQ-032 Instructions 0x40355513 (srai) and 0x00000073 (ecall) -> out_illegal=1 and out_op=0000 for each; with the macro defined, err_count=2.
REQ-033 FIFO full plus a simultaneous pop and in_valid -> the pop is taken and the push is refused (in_ready=0); the next cycle accepts the push; occupancy never exceeds 2.
REQ-034 Assert rst while the FIFO holds 2 entries and push is valid -> next cycle out_valid=0, in_ready=1, err_count=0; with the macro defined and 300 illegal pushes, err_count saturates at 255.
